rs_station: RTL

- Reservation station for non-memory instructions; sits directly downstream of the issue stage.
- Accepts one arithmetic/branch/jump/upper-immediate instruction per cycle with its operand tags and values, already renamed.
- Snoops the two common-data-bus broadcasts, one from the ALU and one from the load/store buffer, to resolve pending operands.
- Dispatches one fully-ready entry per cycle to the ALU, with a registered output.

---
 rtl/rs_station.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rs_station.sv
// Reservation station for non-memory instructions. Holds renamed instructions
// until both operands are resolved from the ALU/LSB broadcast buses, then
// dispatches the lowest-index ready entry to the ALU through registered outputs.
module rs_station #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned OP_W      = 6,
  parameter int unsigned TAG_W     = 5,
  parameter logic [31:0] READY_TAG = 32'hFFFF_FFFF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             en_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic [31:0]      q1_in,
  input  logic [31:0]      v1_in,
  input  logic [31:0]      q2_in,
  input  logic [31:0]      v2_in,
  input  logic [TAG_W-1:0] rob_in,
  output logic             full_o,
  input  logic             alu_cdb_en,
  input  logic [TAG_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [TAG_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             alu_en_o,
  output logic [OP_W-1:0]  alu_op_o,
  output logic [31:0]      alu_v1_o,
  output logic [31:0]      alu_v2_o,
  output logic [TAG_W-1:0] alu_rob_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] v;
  } opnd_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [OP_W-1:0]  op_d   [DEPTH];
  opnd_t            src1_q [DEPTH];
  opnd_t            src1_d [DEPTH];
  opnd_t            src2_q [DEPTH];
  opnd_t            src2_d [DEPTH];
  logic [TAG_W-1:0] rob_q  [DEPTH];
  logic [TAG_W-1:0] rob_d  [DEPTH];

  logic             full_q, full_d;
  logic             alu_en_q, alu_en_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [31:0]      alu_v1_q, alu_v1_d;
  logic [31:0]      alu_v2_q, alu_v2_d;
  logic [TAG_W-1:0] alu_rob_q, alu_rob_d;

  logic [31:0]      alu_tag, lsb_tag;
  logic [DEPTH-1:0] ready;
  logic             disp_vld, free_vld;
  logic [IdxW-1:0]  disp_idx, free_idx;
  logic [CntW-1:0]  busy_cnt;

  assign alu_tag = {{(32-TAG_W){1'b0}}, alu_cdb_rob};
  assign lsb_tag = {{(32-TAG_W){1'b0}}, lsb_cdb_rob};

  // Resolve one operand against both buses; the ALU bus wins on a double match.
  function automatic opnd_t snoop(input opnd_t o,
                                  input logic a_en, input logic [31:0] a_tag,
                                  input logic [31:0] a_val,
                                  input logic l_en, input logic [31:0] l_tag,
                                  input logic [31:0] l_val);
    opnd_t r;
    r = o;
    if (o.q != READY_TAG) begin
      if (a_en && (o.q == a_tag)) begin
        r.q = READY_TAG;
        r.v = a_val;
      end else if (l_en && (o.q == l_tag)) begin
        r.q = READY_TAG;
        r.v = l_val;
      end
    end
    return r;
  endfunction

  // Lowest-index ready entry (dispatch) and lowest-index free entry (insert).
  always_comb begin
    ready    = '0;
    disp_vld = 1'b0;
    disp_idx = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && (src1_q[i].q == READY_TAG) && (src2_q[i].q == READY_TAG);
      if (ready[i]) begin
        disp_vld = 1'b1;
        disp_idx = IdxW'(i);
      end
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Next state: wakeup, dispatch and insert all work from pre-edge state.
  always_comb begin
    busy_d    = busy_q;
    full_d    = full_q;
    alu_en_d  = 1'b0;
    alu_op_d  = alu_op_q;
    alu_v1_d  = alu_v1_q;
    alu_v2_d  = alu_v2_q;
    alu_rob_d = alu_rob_q;
    busy_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      rob_d[i]  = rob_q[i];
      src1_d[i] = busy_q[i] ? snoop(src1_q[i], alu_cdb_en, alu_tag, alu_cdb_val,
                                    lsb_cdb_en, lsb_tag, lsb_cdb_val) : src1_q[i];
      src2_d[i] = busy_q[i] ? snoop(src2_q[i], alu_cdb_en, alu_tag, alu_cdb_val,
                                    lsb_cdb_en, lsb_tag, lsb_cdb_val) : src2_q[i];
    end

    if (clear) begin
      busy_d = '0;
      full_d = 1'b0;
    end else begin
      alu_en_d = disp_vld;
      if (disp_vld) begin
        busy_d[disp_idx] = 1'b0;
        alu_op_d         = op_q[disp_idx];
        alu_v1_d         = src1_q[disp_idx].v;
        alu_v2_d         = src2_q[disp_idx].v;
        alu_rob_d        = rob_q[disp_idx];
      end
      // Free slot was chosen on pre-edge busy, so a just-dispatched entry is never reused here.
      if (en_in && free_vld) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = op_in;
        rob_d[free_idx]  = rob_in;
        src1_d[free_idx] = snoop({q1_in, v1_in}, alu_cdb_en, alu_tag, alu_cdb_val,
                                 lsb_cdb_en, lsb_tag, lsb_cdb_val);
        src2_d[free_idx] = snoop({q2_in, v2_in}, alu_cdb_en, alu_tag, alu_cdb_val,
                                 lsb_cdb_en, lsb_tag, lsb_cdb_val);
      end
      for (int i = 0; i < DEPTH; i++) begin
        busy_cnt = busy_cnt + CntW'(busy_d[i]);
      end
      // One entry of slack covers the issue stage's combinational decision.
      full_d = (busy_cnt >= CntW'(DEPTH - 1));
    end
  end

  // State registers; a low rdy_in freezes everything including outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q    <= '0;
      full_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_rob_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        rob_q[i]  <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      full_q    <= full_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_v1_q  <= alu_v1_d;
      alu_v2_q  <= alu_v2_d;
      alu_rob_q <= alu_rob_d;
      op_q      <= op_d;
      rob_q     <= rob_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
    end
  end

  assign full_o    = full_q;
  assign alu_en_o  = alu_en_q;
  assign alu_op_o  = alu_op_q;
  assign alu_v1_o  = alu_v1_q;
  assign alu_v2_o  = alu_v2_q;
  assign alu_rob_o = alu_rob_q;

endmodule
